// File: rtl/cpx_pkg.sv
// Shared width helpers and conj-mode constants for the complex multiply datapath.
package cpx_pkg;

    localparam logic CPX_MUL  = 1'b0;
    localparam logic CPX_CONJ = 1'b1;

    function automatic int unsigned clog2_f(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(v)) r = i + 1;
        end
        return r;
    endfunction

    function automatic int unsigned prod_bits_f(input int unsigned xb, input int unsigned yb);
        return xb + yb + 1;
    endfunction

    function automatic int unsigned acc_bits_f(input int unsigned pb, input int unsigned acc_len);
        return (acc_len <= 1) ? pb : pb + clog2_f(acc_len);
    endfunction

endpackage

// File: rtl/cpx_product.sv
// Two-stage complex product: registered operands, then registered x*y or x*conj(y).
module cpx_product
    import cpx_pkg::*;
#(
    parameter int unsigned X_BITS = 12,
    parameter int unsigned Y_BITS = 12
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          i_en,
    input  logic                          i_valid,
    input  logic signed [X_BITS-1:0]      i_xi,
    input  logic signed [X_BITS-1:0]      i_xq,
    input  logic signed [Y_BITS-1:0]      i_yi,
    input  logic signed [Y_BITS-1:0]      i_yq,
    input  logic                          i_conj,
    output logic                          o_valid,
    output logic signed [X_BITS+Y_BITS:0] o_i,
    output logic signed [X_BITS+Y_BITS:0] o_q
);

    localparam int unsigned PROD_BITS = prod_bits_f(X_BITS, Y_BITS);

    logic signed [X_BITS-1:0]    r_xi, r_xq;
    logic signed [Y_BITS-1:0]    r_yi, r_yq;
    logic                        r_conj, r_v1, r_v2;
    logic signed [PROD_BITS-1:0] w_ii, w_qq, w_iq, w_qi, w_i, w_q, r_i, r_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_xi   <= '0;
            r_xq   <= '0;
            r_yi   <= '0;
            r_yq   <= '0;
            r_conj <= CPX_MUL;
            r_v1   <= 1'b0;
        end else if (i_en) begin
            r_xi   <= i_xi;
            r_xq   <= i_xq;
            r_yi   <= i_yi;
            r_yq   <= i_yq;
            r_conj <= i_conj;
            r_v1   <= i_valid;
        end
    end

    // Operands are widened first so products and sums are all formed at PROD_BITS.
    assign w_ii = PROD_BITS'(r_xi) * PROD_BITS'(r_yi);
    assign w_qq = PROD_BITS'(r_xq) * PROD_BITS'(r_yq);
    assign w_iq = PROD_BITS'(r_xi) * PROD_BITS'(r_yq);
    assign w_qi = PROD_BITS'(r_xq) * PROD_BITS'(r_yi);

    assign w_i = (r_conj == CPX_CONJ) ? w_ii + w_qq : w_ii - w_qq;
    assign w_q = (r_conj == CPX_CONJ) ? w_qi - w_iq : w_iq + w_qi;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_i  <= '0;
            r_q  <= '0;
            r_v2 <= 1'b0;
        end else if (i_en) begin
            r_i  <= w_i;
            r_q  <= w_q;
            r_v2 <= r_v1;
        end
    end

    assign o_valid = r_v2;
    assign o_i     = r_i;
    assign o_q     = r_q;

endmodule

// File: rtl/cpx_multiply_acc.sv
// Complex multiply-accumulate: sums ACC_LEN products per result, valid/ready on both sides.
module cpx_multiply_acc
    import cpx_pkg::*;
#(
    parameter int unsigned X_BITS   = 12,
    parameter int unsigned Y_BITS   = 12,
    parameter int unsigned ACC_LEN  = 4,
    parameter int unsigned OUT_BITS = 27
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       m_axis_tvalid,
    output logic                       s_axis_tready,
    input  logic signed [X_BITS-1:0]   xi,
    input  logic signed [X_BITS-1:0]   xq,
    input  logic signed [Y_BITS-1:0]   yi,
    input  logic signed [Y_BITS-1:0]   yq,
    input  logic                       conj,
    output logic                       s_axis_tvalid,
    input  logic                       m_axis_tready,
    output logic signed [OUT_BITS-1:0] i_out,
    output logic signed [OUT_BITS-1:0] q_out,
    output logic [$clog2(ACC_LEN):0]   acc_count
);

    localparam int unsigned PROD_BITS = prod_bits_f(X_BITS, Y_BITS);
    localparam int unsigned ACC_BITS  = acc_bits_f(PROD_BITS, ACC_LEN);
    localparam int unsigned CNT_BITS  = clog2_f(ACC_LEN) + 1;
    localparam logic [CNT_BITS-1:0] LAST_CNT = CNT_BITS'(ACC_LEN - 1);

    if (ACC_LEN < 1) begin : g_bad_len
        $error("cpx_multiply_acc: ACC_LEN must be >= 1");
    end
    if (OUT_BITS > ACC_BITS) begin : g_bad_out
        $error("cpx_multiply_acc: OUT_BITS must be <= ACC_BITS");
    end

    logic                        w_en, w_v2, w_last;
    logic signed [PROD_BITS-1:0] w_pi, w_pq;
    logic signed [ACC_BITS-1:0]  w_sum_i, w_sum_q, r_acc_i, r_acc_q;
    logic [CNT_BITS-1:0]         r_cnt;
    logic                        r_out_v;
    logic signed [OUT_BITS-1:0]  r_out_i, r_out_q;

    assign w_en          = !r_out_v || m_axis_tready;
    assign s_axis_tready = w_en && reset_n;

    cpx_product #(
        .X_BITS (X_BITS),
        .Y_BITS (Y_BITS)
    ) u_product (
        .clk     (clk),
        .reset_n (reset_n),
        .i_en    (w_en),
        .i_valid (m_axis_tvalid),
        .i_xi    (xi),
        .i_xq    (xq),
        .i_yi    (yi),
        .i_yq    (yq),
        .i_conj  (conj),
        .o_valid (w_v2),
        .o_i     (w_pi),
        .o_q     (w_pq)
    );

    // A new group ignores the stale accumulator, so groups chain with no bubble.
    assign w_last  = (r_cnt == LAST_CNT);
    assign w_sum_i = ((r_cnt == '0) ? '0 : r_acc_i) + ACC_BITS'(w_pi);
    assign w_sum_q = ((r_cnt == '0) ? '0 : r_acc_q) + ACC_BITS'(w_pq);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_acc_i <= '0;
            r_acc_q <= '0;
            r_cnt   <= '0;
            r_out_v <= 1'b0;
            r_out_i <= '0;
            r_out_q <= '0;
        end else if (w_en) begin
            r_out_v <= w_v2 && w_last;
            if (w_v2) begin
                if (w_last) begin
                    r_cnt   <= '0;
                    r_out_i <= w_sum_i[ACC_BITS-1 -: OUT_BITS];
                    r_out_q <= w_sum_q[ACC_BITS-1 -: OUT_BITS];
                end else begin
                    r_cnt   <= r_cnt + CNT_BITS'(1);
                    r_acc_i <= w_sum_i;
                    r_acc_q <= w_sum_q;
                end
            end
        end
    end

    assign s_axis_tvalid = r_out_v;
    assign i_out         = r_out_i;
    assign q_out         = r_out_q;
    assign acc_count     = r_cnt;

endmodule

// File: tb/tb_cpx_multiply_acc.sv
// Directed and randomised checks of cpx_multiply_acc at ACC_LEN = 1, 3 and 4.
module tb_cpx_multiply_acc;

    logic clk = 1'b0;
    logic reset_n;
    logic signed [11:0] xi, xq, yi, yq;
    logic conj;

    logic tv1, rdy1, sv1, tr1;
    logic signed [24:0] oi1, oq1;
    logic [0:0] cnt1;
    logic tv3, rdy3, sv3, tr3;
    logic signed [26:0] oi3, oq3;
    logic [2:0] cnt3;
    logic tv4, rdy4, sv4, tr4;
    logic signed [26:0] oi4, oq4;
    logic [2:0] cnt4;

    int n_tests = 0;
    int n_fail  = 0;

    logic signed [11:0] vxi [8], vxq [8], vyi [8], vyq [8];
    logic vcj [8];
    longint got_i[$], got_q[$];

    always #5 clk = ~clk;

    cpx_multiply_acc #(.X_BITS(12), .Y_BITS(12), .ACC_LEN(1), .OUT_BITS(25)) u_dut1 (
        .clk(clk), .reset_n(reset_n), .m_axis_tvalid(tv1), .s_axis_tready(rdy1),
        .xi(xi), .xq(xq), .yi(yi), .yq(yq), .conj(conj), .s_axis_tvalid(sv1),
        .m_axis_tready(tr1), .i_out(oi1), .q_out(oq1), .acc_count(cnt1)
    );

    cpx_multiply_acc #(.X_BITS(12), .Y_BITS(12), .ACC_LEN(3), .OUT_BITS(27)) u_dut3 (
        .clk(clk), .reset_n(reset_n), .m_axis_tvalid(tv3), .s_axis_tready(rdy3),
        .xi(xi), .xq(xq), .yi(yi), .yq(yq), .conj(conj), .s_axis_tvalid(sv3),
        .m_axis_tready(tr3), .i_out(oi3), .q_out(oq3), .acc_count(cnt3)
    );

    cpx_multiply_acc #(.X_BITS(12), .Y_BITS(12), .ACC_LEN(4), .OUT_BITS(27)) u_dut4 (
        .clk(clk), .reset_n(reset_n), .m_axis_tvalid(tv4), .s_axis_tready(rdy4),
        .xi(xi), .xq(xq), .yi(yi), .yq(yq), .conj(conj), .s_axis_tvalid(sv4),
        .m_axis_tready(tr4), .i_out(oi4), .q_out(oq4), .acc_count(cnt4)
    );

    task automatic set_vec(input int k, input int a, input int b, input int c, input int d,
                           input logic cj);
        vxi[k] = 12'(a);
        vxq[k] = 12'(b);
        vyi[k] = 12'(c);
        vyq[k] = 12'(d);
        vcj[k] = cj;
    endtask

    // Streams vectors 0..n-1 into the ACC_LEN=4 instance with the sink always ready.
    task automatic stream4(input int n, input int extra);
        int idx;
        idx = 0;
        got_i.delete();
        got_q.delete();
        tr4 = 1'b1;
        for (int c = 0; c < n + extra; c++) begin
            if (idx < n) begin
                xi = vxi[idx]; xq = vxq[idx]; yi = vyi[idx]; yq = vyq[idx]; conj = vcj[idx];
                tv4 = 1'b1;
            end else begin
                tv4 = 1'b0;
            end
            @(negedge clk);
            if (tv4 && rdy4) idx++;
            if (sv4 && tr4) begin
                got_i.push_back(longint'(oi4));
                got_q.push_back(longint'(oq4));
            end
            @(posedge clk);
            #1;
        end
        tv4 = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_tests++;
        if (sv4 !== 1'b0 || oi4 !== 27'sd0 || oq4 !== 27'sd0 || cnt4 !== 3'd0) begin
            n_fail++;
            $display("FAIL reset_out4: sv=%0b i=%0d q=%0d cnt=%0d, required 0 0 0 0",
                     sv4, oi4, oq4, cnt4);
        end
        n_tests++;
        if (sv1 !== 1'b0 || sv3 !== 1'b0 || oi1 !== 25'sd0 || oi3 !== 27'sd0) begin
            n_fail++;
            $display("FAIL reset_out13: sv1=%0b sv3=%0b i1=%0d i3=%0d, required all 0",
                     sv1, sv3, oi1, oi3);
        end
        n_tests++;
        if (rdy1 !== 1'b0 || rdy4 !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ready: rdy1=%0b rdy4=%0b, required 0 0", rdy1, rdy4);
        end
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        n_tests++;
        if (rdy4 !== 1'b1 || rdy3 !== 1'b1) begin
            n_fail++;
            $display("FAIL ready_after_reset: rdy3=%0b rdy4=%0b, required 1 1", rdy3, rdy4);
        end
    endtask

    task automatic test_single_latency();
        xi = 12'sd3; xq = 12'sd4; yi = 12'sd5; yq = -12'sd2; conj = 1'b0;
        tv1 = 1'b1;
        tr1 = 1'b1;
        @(negedge clk);
        n_tests++;
        if (rdy1 !== 1'b1) begin
            n_fail++;
            $display("FAIL single_ready: got %0b, required 1", rdy1);
        end
        @(posedge clk);
        #1;
        tv1 = 1'b0;
        n_tests++;
        if (sv1 !== 1'b0) begin
            n_fail++;
            $display("FAIL single_early_k: tvalid %0b, required 0", sv1);
        end
        @(posedge clk);
        #1;
        n_tests++;
        if (sv1 !== 1'b0) begin
            n_fail++;
            $display("FAIL single_early_k1: tvalid %0b, required 0", sv1);
        end
        @(posedge clk);
        #1;
        n_tests++;
        if (sv1 !== 1'b1 || oi1 !== 25'sd23 || oq1 !== 25'sd14) begin
            n_fail++;
            $display("FAIL single_result: tvalid=%0b i=%0d q=%0d, required 1 23 14",
                     sv1, oi1, oq1);
        end
        @(posedge clk);
        #1;
        n_tests++;
        if (sv1 !== 1'b0) begin
            n_fail++;
            $display("FAIL single_consumed: tvalid %0b, required 0", sv1);
        end
    endtask

    task automatic test_acc4_conj();
        for (int i = 0; i < 4; i++) set_vec(i, 100, -50, 100, -50, 1'b1);
        stream4(4, 8);
        n_tests++;
        if (got_i.size() != 1) begin
            n_fail++;
            $display("FAIL acc4_count: %0d outputs, required 1", got_i.size());
        end
        n_tests++;
        if (got_i.size() == 0 || got_i[0] != 64'sd50000 || got_q[0] != 64'sd0) begin
            n_fail++;
            $display("FAIL acc4_value: i=%0d q=%0d, required 50000 0",
                     got_i.size() ? got_i[0] : 0, got_q.size() ? got_q[0] : 0);
        end
        n_tests++;
        if (cnt4 !== 3'd0) begin
            n_fail++;
            $display("FAIL acc4_cnt: acc_count %0d, required 0", cnt4);
        end
    endtask

    task automatic test_full_scale();
        for (int i = 0; i < 4; i++) set_vec(i, -2048, -2048, -2048, -2048, 1'b1);
        stream4(4, 8);
        n_tests++;
        if (got_i.size() != 1 || got_i[0] != 64'sd33554432 || got_q[0] != 64'sd0) begin
            n_fail++;
            $display("FAIL full_scale: n=%0d i=%0d q=%0d, required 1 33554432 0",
                     got_i.size(), got_i.size() ? got_i[0] : 0,
                     got_q.size() ? got_q[0] : 0);
        end
    endtask

    task automatic test_backpressure();
        int idx;
        int stall;
        idx = 0;
        stall = 0;
        got_i.delete();
        got_q.delete();
        for (int i = 0; i < 4; i++) set_vec(i, 1, 0, i + 1, 0, 1'b0);
        for (int i = 0; i < 4; i++) set_vec(i + 4, 1, 0, 10 * (i + 1), 0, 1'b0);
        tr4 = 1'b0;
        for (int c = 0; c < 40; c++) begin
            if (idx < 8) begin
                xi = vxi[idx]; xq = vxq[idx]; yi = vyi[idx]; yq = vyq[idx]; conj = vcj[idx];
                tv4 = 1'b1;
            end else begin
                tv4 = 1'b0;
            end
            @(negedge clk);
            if (sv4 && !tr4) begin
                stall++;
                n_tests++;
                if (oi4 !== 27'sd10 || oq4 !== 27'sd0 || rdy4 !== 1'b0) begin
                    n_fail++;
                    $display("FAIL bp_hold: i=%0d q=%0d ready=%0b, required 10 0 0",
                             oi4, oq4, rdy4);
                end
            end
            if (tv4 && rdy4) idx++;
            if (sv4 && tr4) begin
                got_i.push_back(longint'(oi4));
                got_q.push_back(longint'(oq4));
            end
            @(posedge clk);
            #1;
            if (stall == 5) tr4 = 1'b1;
        end
        tv4 = 1'b0;
        tr4 = 1'b1;
        n_tests++;
        if (got_i.size() != 2) begin
            n_fail++;
            $display("FAIL bp_count: %0d outputs, required 2", got_i.size());
        end
        n_tests++;
        if (got_i.size() < 2 || got_i[0] != 64'sd10 || got_i[1] != 64'sd100 ||
            got_q[0] != 64'sd0 || got_q[1] != 64'sd0) begin
            n_fail++;
            $display("FAIL bp_values: i0=%0d i1=%0d, required 10 100",
                     got_i.size() > 0 ? got_i[0] : 0, got_i.size() > 1 ? got_i[1] : 0);
        end
    endtask

    task automatic test_random_acc3();
        longint ei[$], eq[$];
        longint ai, aq, pi, pq, li, lq, mi, mq, exp_i, exp_q;
        int k, sent, outs;
        ai = 0; aq = 0; k = 0; sent = 0; outs = 0;
        for (int c = 0; c < 5000; c++) begin
            if (sent < 1000) begin
                tv3  = ($urandom_range(0, 3) != 0);
                xi   = 12'($urandom);
                xq   = 12'($urandom);
                yi   = 12'($urandom);
                yq   = 12'($urandom);
                conj = 1'($urandom);
            end else begin
                tv3 = 1'b0;
            end
            tr3 = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            if (tv3 && rdy3) begin
                li = longint'(xi); lq = longint'(xq); mi = longint'(yi); mq = longint'(yq);
                pi = conj ? li * mi + lq * mq : li * mi - lq * mq;
                pq = conj ? lq * mi - li * mq : li * mq + lq * mi;
                ai = (k == 0) ? pi : ai + pi;
                aq = (k == 0) ? pq : aq + pq;
                k++;
                sent++;
                if (k == 3) begin
                    ei.push_back(ai);
                    eq.push_back(aq);
                    k = 0;
                end
            end
            if (sv3 && tr3) begin
                outs++;
                n_tests++;
                if (ei.size() == 0) begin
                    n_fail++;
                    $display("FAIL rand_extra: output %0d i=%0d with none expected", outs, oi3);
                end else begin
                    exp_i = ei.pop_front();
                    exp_q = eq.pop_front();
                    if (longint'(oi3) != exp_i || longint'(oq3) != exp_q) begin
                        n_fail++;
                        $display("FAIL rand_value: output %0d got %0d,%0d required %0d,%0d",
                                 outs, oi3, oq3, exp_i, exp_q);
                    end
                end
            end
            @(posedge clk);
            #1;
        end
        tv3 = 1'b0;
        tr3 = 1'b1;
        n_tests++;
        if (outs != 333 || ei.size() != 0 || sent != 1000) begin
            n_fail++;
            $display("FAIL rand_count: outputs %0d pending %0d sent %0d, required 333 0 1000",
                     outs, ei.size(), sent);
        end
    endtask

    task automatic test_reset_mid_group();
        for (int i = 0; i < 2; i++) set_vec(i, 1, 0, 7, 0, 1'b0);
        stream4(2, 4);
        n_tests++;
        if (cnt4 !== 3'd2 || got_i.size() != 0) begin
            n_fail++;
            $display("FAIL mid_partial: acc_count %0d outputs %0d, required 2 0",
                     cnt4, got_i.size());
        end
        #2;
        reset_n = 1'b0;
        #1;
        n_tests++;
        if (oi4 !== 27'sd0 || oq4 !== 27'sd0 || sv4 !== 1'b0 || cnt4 !== 3'd0 ||
            rdy4 !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset: i=%0d q=%0d tvalid=%0b cnt=%0d ready=%0b, required 0s",
                     oi4, oq4, sv4, cnt4, rdy4);
        end
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) set_vec(i, 1, 0, 2, 0, 1'b0);
        stream4(4, 8);
        n_tests++;
        if (got_i.size() != 1 || got_i[0] != 64'sd8 || got_q[0] != 64'sd0) begin
            n_fail++;
            $display("FAIL mid_next_group: n=%0d i=%0d, required 1 8",
                     got_i.size(), got_i.size() ? got_i[0] : 0);
        end
    endtask

    initial begin
        reset_n = 1'b0;
        xi = '0; xq = '0; yi = '0; yq = '0; conj = 1'b0;
        tv1 = 1'b0; tv3 = 1'b0; tv4 = 1'b0;
        tr1 = 1'b1; tr3 = 1'b1; tr4 = 1'b1;
        test_reset();
        test_single_latency();
        test_acc4_conj();
        test_full_scale();
        test_backpressure();
        test_random_acc3();
        test_reset_mid_group();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/cpx_multiply_acc.md
Name: cpx_multiply_acc

Overview:
- Parametrised successor of the single-product complex multiplier.
- Computes x·y or x·conj(y) per sample and sums ACC_LEN consecutive products into one complex result.
- Uses AXI-stream-style valid/ready on both sides, with full backpressure.
- Sits in the CAF datapath as the dot-product core feeding the correlation/magnitude stages; ACC_LEN=1 gives a plain pipelined multiplier.

Parameters:
- X_BITS, 12, signed width of xi and xq.
- Y_BITS, 12, signed width of yi and yq.
- ACC_LEN, 4, number of products summed per output; must be >= 1.
- OUT_BITS, 27, output width per rail; must be <= ACC_BITS.
- Derived, not overridable:
  - PROD_BITS = X_BITS+Y_BITS+1.
  - ACC_BITS = PROD_BITS+$clog2(ACC_LEN), or PROD_BITS when ACC_LEN=1.

Ports:
- clk  in  1  rising-edge clock.
- reset_n  in  1  asynchronous active-low reset.
- m_axis_tvalid  in  1  input sample valid.
- s_axis_tready  out  1  block can accept an input sample.
- xi, xq  in  X_BITS each  signed x sample.
- yi, yq  in  Y_BITS each  signed y sample.
- conj  in  1  sampled with each input; 1 selects x·conj(y).
- s_axis_tvalid  out  1  result valid.
- m_axis_tready  in  1  downstream accepts result.
- i_out, q_out  out  OUT_BITS each  signed accumulated result.
- acc_count  out  $clog2(ACC_LEN)+1  accepted samples in the current group (debug/status).

Behaviour:
- Reset, asynchronous assert, synchronous release: all pipeline valids=0, s_axis_tvalid=0, i_out=q_out=0, acc_count=0, accumulators=0.
- A reset mid-group discards the partial sum.
- Global enable: en = !s_axis_tvalid || m_axis_tready. s_axis_tready = en && reset_n. An input transfer occurs on a rising edge where m_axis_tvalid && s_axis_tready.
- Pipeline stages; all advance only when en=1, and when en=0 every stage holds its value:
  - S1: register xi, xq, yi, yq, conj, valid.
  - S2: four signed products, sign-extended to PROD_BITS.
    - conj=0: I = xi·yi − xq·yq, Q = xi·yq + xq·yi.
    - conj=1: I = xi·yi + xq·yq, Q = xq·yi − xi·yq.
    - Register I and Q.
  - S3: accumulate at ACC_BITS.
- Accumulation, on each valid S2 product:
  - If acc_count=0, acc = product; otherwise acc += product; then acc_count += 1.
  - When acc_count reaches ACC_LEN, the output register loads acc+product, s_axis_tvalid=1, acc_count=0, and the next group starts clean with no bubble.
- Output scaling: i_out = acc[ACC_BITS-1 -: OUT_BITS]. This is truncation (arithmetic drop of LSBs), with no rounding and no saturation.
- Overflow: none is possible at ACC_BITS. The full-scale −2^(X_BITS-1)·−2^(Y_BITS-1) case must fit PROD_BITS.
- Latency: for the last sample of a group accepted at edge k, s_axis_tvalid rises after edge k+2 when no backpressure is applied.
- Throughput: one sample per cycle while m_axis_tready=1.
- Output handshake: the result is held stable until s_axis_tvalid && m_axis_tready. On the same edge it may be replaced by a new result, giving back-to-back outputs.
- Gaps: m_axis_tvalid=0 inserts bubbles, and bubbles do not advance acc_count.
- conj is per-sample; mixing modes within a group is legal, and each product uses its own conj.
- Sim-time check: error if OUT_BITS > ACC_BITS or ACC_LEN < 1.

Decomposition:
- Shared package cpx_pkg: PROD_BITS/ACC_BITS width functions, a clog2 helper, and the conj mode constants CPX_MUL=0, CPX_CONJ=1.
- Sub-module cpx_product: S1 and S2 (registered inputs, 4 multiplies, conj add/sub, enable input). It is reusable by the existing multiplier.
- Accumulate, output, and handshake logic stay in the top module.

Test Plan:
1. ACC_LEN=1, conj=0, x=(3,4), y=(5,−2) -> i_out=23, q_out=14, s_axis_tvalid after edge k+2.
2. ACC_LEN=4, conj=1, four samples x=y=(100,−50) -> i_out=50000, q_out=0, exactly one output, acc_count back to 0.
3. Full-scale: X_BITS=Y_BITS=12, ACC_LEN=4, x=y=(−2048,−2048), conj=1, four times -> i_out=33554432, q_out=0, no wrap.
4. Backpressure: m_axis_tready=0 for 5 cycles with output valid -> i_out/q_out stable, s_axis_tready=0, no input consumed. On release, continuous flow resumes with no lost or duplicated results.
5. Random m_axis_tvalid gaps and random m_axis_tready, 1000 samples, ACC_LEN=3 -> outputs match the golden model file (same "%d,%d" format); output count = 333.
6. reset_n pulse after 2 of 4 group samples -> all outputs 0 immediately. The next 4 samples produce their own sum only.
